// File: rtl/systolic_drain.sv
// Drains size*size PE sums from the systolic datapath into a one-entry val/rdy output register.
// Define SYSTOLIC_DRAIN_COL_MAJOR_EN for column-major sweep order; default is row-major.
module systolic_drain #(
   parameter int size  = 16,
   parameter int nbits = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(size)-1:0]  out_rsel,
   output logic [$clog2(size)-1:0]  out_csel,
   input  logic [nbits-1:0]         s_in,
   output logic [nbits-1:0]         out_msg,
   output logic                     out_last,
   output logic                     out_val,
   input  logic                     out_rdy
);

   localparam int SW = $clog2(size);
   localparam logic [SW-1:0] SEL_MAX = SW'(size - 1);

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

   state_t            state_q, state_d;
   logic [SW-1:0]     rsel_q, rsel_d, csel_q, csel_d;
   logic [nbits-1:0]  msg_q, msg_d;
   logic              val_q, val_d, last_q, last_d, done_q, done_d, busy_q, busy_d;
   logic              hs, load, at_final;

   always_comb begin
      state_d  = state_q;
      rsel_d   = rsel_q;
      csel_d   = csel_q;
      msg_d    = msg_q;
      val_d    = val_q;
      last_d   = last_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      hs       = val_q && out_rdy;
      load     = (state_q == DRAIN) && (!val_q || out_rdy);
      at_final = (rsel_q == SEL_MAX) && (csel_q == SEL_MAX);

      // An accepted word empties the register unless a new one is loaded below.
      if (hs) val_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = DRAIN;
               busy_d  = 1'b1;
               rsel_d  = '0;
               csel_d  = '0;
            end
         end
         DRAIN: begin
            if (load) begin
               msg_d  = s_in;
               val_d  = 1'b1;
               last_d = at_final;
               if (at_final) begin
                  state_d = FLUSH;
                  rsel_d  = '0;
                  csel_d  = '0;
               end else begin
`ifdef SYSTOLIC_DRAIN_COL_MAJOR_EN
                  if (rsel_q == SEL_MAX) begin
                     rsel_d = '0;
                     csel_d = csel_q + 1'b1;
                  end else begin
                     rsel_d = rsel_q + 1'b1;
                  end
`else
                  if (csel_q == SEL_MAX) begin
                     csel_d = '0;
                     rsel_d = rsel_q + 1'b1;
                  end else begin
                     csel_d = csel_q + 1'b1;
                  end
`endif
               end
            end
         end
         FLUSH: begin
            if (hs) begin
               last_d  = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rsel_q  <= '0;
         csel_q  <= '0;
         msg_q   <= '0;
         val_q   <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rsel_q  <= rsel_d;
         csel_q  <= csel_d;
         msg_q   <= msg_d;
         val_q   <= val_d;
         last_q  <= last_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign out_rsel = rsel_q;
   assign out_csel = csel_q;
   assign out_msg  = msg_q;
   assign out_last = last_q;
   assign out_val  = val_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: datapath table model plus scoreboard of expected sweep order.
// Honours SYSTOLIC_DRAIN_COL_MAJOR_EN for the expected word order.
module tb_systolic_drain;
   localparam int size    = 4;
   localparam int nbits   = 16;
   localparam int sw      = 2;
   localparam int n_words = size * size;

   logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_rdy = 1'b0;
   logic              busy, done, out_last, out_val;
   logic [sw-1:0]     out_rsel, out_csel;
   logic [nbits-1:0]  s_in, out_msg;
   logic [nbits-1:0]  tbl [size][size];
   int                errors = 0, checks = 0;

   always #5 clk = ~clk;

   // Datapath: selected PE sum is a combinational lookup of the current select.
   always_comb s_in = tbl[out_rsel][out_csel];

   systolic_drain #(.size(size), .nbits(nbits)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .out_rsel(out_rsel), .out_csel(out_csel), .s_in(s_in), .out_msg(out_msg),
      .out_last(out_last), .out_val(out_val), .out_rdy(out_rdy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_sel(input int k);
`ifdef SYSTOLIC_DRAIN_COL_MAJOR_EN
      return {2'(k % size), 2'(k / size)};
`else
      return {2'(k / size), 2'(k % size)};
`endif
   endfunction

   function automatic logic [nbits-1:0] exp_word(input int k);
      logic [3:0] rc;
      rc = exp_sel(k);
      return tbl[rc[3:2]][rc[1:0]];
   endfunction

   task automatic fill(input bit rnd);
      for (int r = 0; r < size; r++)
         for (int c = 0; c < size; c++)
            tbl[r][c] = rnd ? nbits'($urandom) : nbits'(16 * r + c);
   endtask

   // mode 0: rdy always 1, 1: toggles 1,0,..., 2: random
   task automatic drain(input int mode, input bit chk_lat);
      int n = 0;
      int cyc = 0;
      bit fin = 0;
      logic pv, pr, pl;
      logic [nbits-1:0] pm;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_val", out_val, 0);
      chk("start_sel", {out_rsel, out_csel}, 0);
      while (!fin && cyc < 400) begin
         out_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         pv = out_val; pr = out_rdy; pm = out_msg; pl = out_last;
         step();
         cyc++;
         if (pv && pr) begin
            chk("word", pm, exp_word(n));
            chk("last", pl, n == n_words - 1);
            n++;
            fin = (n == n_words);
         end else if (pv) begin
            chk("stall_val", out_val, 1);
            chk("stall_msg", out_msg, pm);
         end
         chk("done", done, fin);
         chk("busy", busy, !fin);
      end
      chk("drain_count", n, n_words);
      if (chk_lat) chk("latency", cyc, n_words + 1);
      step();
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_val", out_val, 0);
   endtask

   initial begin
      int n, dn;
      logic pv, pr;
      logic [nbits-1:0] pm;

      fill(1'b0);
      step(); step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_val", out_val, 0);
      chk("rst_last", out_last, 0);
      chk("rst_msg", out_msg, 0);
      chk("rst_sel", {out_rsel, out_csel}, 0);
      rst_n = 1'b1;
      step();

      drain(0, 1'b1);
      drain(1, 1'b0);
      fill(1'b1);
      drain(2, 1'b0);

      // start held high: two back-to-back drains, mid-drain pulses ignored
      n = 0; dn = 0;
      out_rdy = 1'b1;
      for (int c = 0; c < 60; c++) begin
         start = (c < 36);
         pv = out_val; pm = out_msg;
         step();
         if (pv) begin
            chk("b2b_word", pm, exp_word(n % n_words));
            n++;
         end
         if (done) dn++;
      end
      start = 1'b0;
      chk("b2b_words", n, 2 * n_words);
      chk("b2b_dones", dn, 2);

      // hold word 0 under a 10-cycle stall
      out_rdy = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      for (int c = 0; c < 10; c++) begin
         step();
         chk("hold_val", out_val, 1);
         chk("hold_msg", out_msg, exp_word(0));
         chk("hold_sel", {out_rsel, out_csel}, exp_sel(1));
         chk("hold_done", done, 0);
      end

      // release, take 7 words, then reset mid-drain
      out_rdy = 1'b1;
      n = 0;
      for (int c = 0; c < 20 && n < 7; c++) begin
         pv = out_val; pr = out_rdy; pm = out_msg;
         step();
         if (pv && pr) begin
            chk("pre_rst_word", pm, exp_word(n));
            n++;
         end
      end
      chk("pre_rst_count", n, 7);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_rst_val", out_val, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_sel", {out_rsel, out_csel}, 0);
      chk("mid_rst_msg", out_msg, 0);
      chk("mid_rst_last", out_last, 0);
      step();
      chk("post_rst_busy", busy, 0);
      drain(0, 1'b1);
      fill(1'b1);
      drain(2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
